// File: rtl/aurora_adc_pkg.sv
// Shared definitions for the Aurora ADC frame-alignment logic.
// State encodings and default framing constants used by the controller.
package aurora_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RUN  = 2'd2
  } frm_state_e;

  localparam int unsigned FRAME_BEATS_DEF = 9;
  localparam int unsigned LOCK_FRAMES_DEF = 4;
  localparam logic [15:0] SYNC_WORD_DEF   = 16'hEB90;

endpackage

// File: rtl/aurora_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module aurora_sat_cnt #(
  parameter int unsigned CNT_WD = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [CNT_WD-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_WD'(1);
    end
  end

endmodule

// File: rtl/aurora_20g_adc_frame_ctrl.sv
// Frame-alignment controller for the 20G Aurora ADC parser: tracks tlast position
// and header sync word, drives parser_rst for realignment and gates stream_en on lock.
module aurora_20g_adc_frame_ctrl
  import aurora_adc_pkg::*;
#(
  parameter int unsigned FRAME_BEATS = FRAME_BEATS_DEF,
  parameter int unsigned HEAD_WD     = 64,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int unsigned CNT_WD      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic               cfg_hdr_chk,
  input  logic               cfg_clr,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  input  logic               head_vld,
  input  logic [HEAD_WD-1:0] head_data,
  output logic               parser_rst,
  output logic               stream_en,
  output logic               locked,
  output logic               lock_lost,
  output logic [CNT_WD-1:0]  frm_cnt,
  output logic [CNT_WD-1:0]  err_cnt
);

  localparam int unsigned BCNT_WD = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BCNT_WD-1:0] LAST_BEAT = BCNT_WD'(FRAME_BEATS - 1);
  localparam logic [7:0] LOCK_GOOD = 8'(LOCK_FRAMES);

  frm_state_e         state_q, state_d;
  logic [BCNT_WD-1:0] bcnt_q, bcnt_d;
  logic [7:0]         good_q, good_d;
  logic               frm_inc, err_inc;
  logic               parser_rst_d, stream_en_d, lock_lost_d;
  logic               at_last, tlast_err, hdr_err;
  logic               unused_head_low;

  assign unused_head_low = ^head_data[HEAD_WD-17:0];

  assign at_last   = (bcnt_q == LAST_BEAT);
  assign tlast_err = s_axis_tvalid && (s_axis_tlast != at_last);
  assign hdr_err   = cfg_hdr_chk && head_vld && (head_data[HEAD_WD-1 -: 16] != SYNC_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      good_q     <= '0;
      parser_rst <= 1'b1;
      stream_en  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      good_q     <= good_d;
      parser_rst <= parser_rst_d;
      stream_en  <= stream_en_d;
      lock_lost  <= lock_lost_d;
    end
  end

  // good is held at zero outside RUN so a stale count can never re-lock on re-entry
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    good_d  = good_q;
    frm_inc = 1'b0;
    err_inc = 1'b0;
    if (!cfg_en) begin
      state_d = ST_IDLE;
      bcnt_d  = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          bcnt_d  = '0;
          good_d  = '0;
        end
        ST_HUNT: begin
          bcnt_d = '0;
          good_d = '0;
          if (s_axis_tvalid && s_axis_tlast) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hdr_err || tlast_err) begin
            state_d = ST_HUNT;
            bcnt_d  = '0;
            good_d  = '0;
            err_inc = 1'b1;
          end else if (s_axis_tvalid) begin
            if (at_last) begin
              bcnt_d  = '0;
              frm_inc = 1'b1;
              if (good_q < LOCK_GOOD) good_d = good_q + 8'd1;
            end else begin
              bcnt_d = bcnt_q + BCNT_WD'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
          good_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    parser_rst_d = (state_d != ST_RUN);
    stream_en_d  = (state_d == ST_RUN) && (good_q >= LOCK_GOOD);
    lock_lost_d  = stream_en && !stream_en_d;
  end

  assign locked = stream_en;

  aurora_sat_cnt #(.CNT_WD(CNT_WD)) u_frm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frm_inc),
    .clr   (cfg_clr),
    .cnt   (frm_cnt)
  );

  aurora_sat_cnt #(.CNT_WD(CNT_WD)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (cfg_clr),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_aurora_20g_adc_frame_ctrl.sv
// Bench for aurora_20g_adc_frame_ctrl: a cycle model feeds a scoreboard queue,
// two instances (32-bit and 4-bit counters) share stimulus.
module tb_aurora_20g_adc_frame_ctrl;

  localparam int FB = 9;
  localparam int LF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0, cfg_hdr_chk = 1'b0, cfg_clr = 1'b0;
  logic        tvalid = 1'b0, tlast = 1'b0, head_vld = 1'b0;
  logic [63:0] head_data = '0;

  logic        pr, se, lk, ll;
  logic [31:0] fc, ec;
  logic        pr4, se4, lk4, ll4;
  logic [3:0]  fc4, ec4;

  always #5 clk = ~clk;

  aurora_20g_adc_frame_ctrl #(.CNT_WD(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_hdr_chk(cfg_hdr_chk), .cfg_clr(cfg_clr),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .head_vld(head_vld), .head_data(head_data),
    .parser_rst(pr), .stream_en(se), .locked(lk), .lock_lost(ll), .frm_cnt(fc), .err_cnt(ec)
  );

  aurora_20g_adc_frame_ctrl #(.CNT_WD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_hdr_chk(cfg_hdr_chk), .cfg_clr(cfg_clr),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .head_vld(head_vld), .head_data(head_data),
    .parser_rst(pr4), .stream_en(se4), .locked(lk4), .lock_lost(ll4), .frm_cnt(fc4), .err_cnt(ec4)
  );

  typedef struct packed {
    logic        pr, se, lk, ll;
    logic [31:0] fc, ec;
    logic        pr4, se4, lk4, ll4;
    logic [3:0]  fc4, ec4;
  } obs_t;

  obs_t q_exp[$];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;

  // reference model state: 0 idle, 1 hunt, 2 run
  int          m_st = 0, m_b = 0, m_good = 0;
  logic        m_pr = 1'b1, m_se = 1'b0, m_ll = 1'b0;
  logic [31:0] m_f = '0, m_e = '0;
  logic [3:0]  m_f4 = '0, m_e4 = '0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_step();
    int   ns, good_old;
    logic fi, ei, hb, new_se;
    good_old = m_good;
    hb = cfg_hdr_chk && head_vld && (head_data[63:48] != 16'hEB90);
    ns = m_st; fi = 1'b0; ei = 1'b0;
    if (!cfg_en) begin
      ns = 0; m_b = 0; m_good = 0;
    end else if (m_st == 0) begin
      ns = 1;
    end else if (m_st == 1) begin
      if (tvalid && tlast) begin ns = 2; m_b = 0; m_good = 0; end
    end else begin
      if (hb || (tvalid && (tlast != (m_b == FB-1)))) begin
        ns = 1; m_b = 0; m_good = 0; ei = 1'b1;
      end else if (tvalid) begin
        if (m_b == FB-1) begin
          m_b = 0; fi = 1'b1;
          if (m_good < LF) m_good++;
        end else m_b++;
      end
    end
    new_se = (ns == 2) && (good_old >= LF);
    m_ll = m_se && !new_se;
    m_se = new_se;
    m_pr = (ns != 2);
    m_st = ns;
    if (cfg_clr) begin
      m_f = '0; m_e = '0; m_f4 = '0; m_e4 = '0;
    end else begin
      if (fi && m_f  != 32'hFFFF_FFFF) m_f  = m_f + 1;
      if (ei && m_e  != 32'hFFFF_FFFF) m_e  = m_e + 1;
      if (fi && m_f4 != 4'hF)          m_f4 = m_f4 + 1;
      if (ei && m_e4 != 4'hF)          m_e4 = m_e4 + 1;
    end
  endtask

  // one clock: drive, predict, push; after the edge pop and compare
  task automatic cyc(input logic tv, input logic tl, input logic hv = 1'b0,
                     input logic [15:0] hw = 16'h0000);
    obs_t e, o;
    tvalid = tv; tlast = tl; head_vld = hv;
    head_data = {hw, $urandom(), 16'($urandom())};
    model_step();
    e = '{pr: m_pr, se: m_se, lk: m_se, ll: m_ll, fc: m_f, ec: m_e,
          pr4: m_pr, se4: m_se, lk4: m_se, ll4: m_ll, fc4: m_f4, ec4: m_e4};
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    ncyc++;
    o = '{pr: pr, se: se, lk: lk, ll: ll, fc: fc, ec: ec,
          pr4: pr4, se4: se4, lk4: lk4, ll4: ll4, fc4: fc4, ec4: ec4};
    e = q_exp.pop_front();
    checks++;
    assert (o === e)
    else begin
      failures++;
      $error("FAIL sb_cycle%0d observed=%h expected=%h", ncyc, o, e);
    end
  endtask

  // n beats, tlast on beat last_idx, optional header beat and random tvalid gaps
  task automatic frame(input int n = FB, input int last_idx = FB-1, input int hdr_idx = -1,
                       input logic [15:0] hw = 16'hEB90, input bit gaps = 0, input bit clr_last = 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 0) cyc(1'b0, 1'b0);
      if (clr_last && i == last_idx) cfg_clr = 1'b1;
      cyc(1'b1, i == last_idx, i == hdr_idx, (i == hdr_idx) ? hw : 16'h0000);
      cfg_clr = 1'b0;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_parser_rst", pr, 1'b1);
    chk("rst_stream_en", se, 1'b0);
    chk("rst_lock_lost", ll, 1'b0);
    chk("rst_frm_cnt", fc, 0);
    chk("rst_err_cnt", ec, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // initial sync and lock
    cfg_en = 1'b1;
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("hunt_parser_rst", pr, 1'b1);
    cyc(1'b1, 1'b1);
    chk("sync_parser_rst_low", pr, 1'b0);
    for (int i = 0; i < 4; i++) frame();
    chk("lock_not_yet", se, 1'b0);
    frame();
    chk("t1_stream_en", se, 1'b1);
    chk("t1_locked", lk, 1'b1);
    chk("t1_frm_cnt", fc, 5);
    chk("t1_err_cnt", ec, 0);

    // early tlast on beat 6
    frame(7, 6);
    chk("t2_err_cnt", ec, 1);
    chk("t2_lock_lost", ll, 1'b1);
    chk("t2_stream_en", se, 1'b0);
    chk("t2_parser_rst", pr, 1'b1);
    cyc(1'b0, 1'b0);
    chk("t2_lock_lost_pulse", ll, 1'b0);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) frame();
    cyc(1'b0, 1'b0);
    chk("t2_relock", se, 1'b1);
    chk("t2_frm_cnt", fc, 9);

    // header check
    cfg_hdr_chk = 1'b1;
    frame(FB, FB-1, 4, 16'hEB90);
    chk("t3_good_hdr_frm", fc, 10);
    frame(5, -1, 4, 16'h1234);
    chk("t3_hdr_err_cnt", ec, 2);
    chk("t3_hdr_lock_lost", ll, 1'b1);
    chk("t3_hdr_parser_rst", pr, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) frame();
    cyc(1'b0, 1'b0);
    chk("t3_relock", se, 1'b1);
    cfg_hdr_chk = 1'b0;
    frame(FB, FB-1, 4, 16'h1234);
    chk("t3_nochk_err_cnt", ec, 2);
    chk("t3_nochk_lock", se, 1'b1);
    chk("t3_nochk_frm_cnt", fc, 15);

    // random tvalid gaps
    for (int i = 0; i < 20; i++) frame(FB, FB-1, -1, 16'h0, 1);
    chk("t4_frm_cnt", fc, 35);
    chk("t4_err_cnt", ec, 2);
    chk("t4_lock", se, 1'b1);

    // cfg_en drop mid-frame
    frame(3, -1);
    cfg_en = 1'b0;
    cyc(1'b1, 1'b0);
    chk("t5_parser_rst", pr, 1'b1);
    chk("t5_lock_lost", ll, 1'b1);
    chk("t5_stream_en", se, 1'b0);
    chk("t5_frm_cnt", fc, 35);
    cyc(1'b1, 1'b1);
    chk("t5_idle_hold", pr, 1'b1);
    cfg_en = 1'b1;
    cfg_hdr_chk = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'hDEAD);
    chk("t5_hunt_hdr_ignored", ec, 2);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) frame();
    cyc(1'b0, 1'b0);
    chk("t5_relock", se, 1'b1);
    cfg_hdr_chk = 1'b0;

    // saturation on the narrow instance and clear vs increment
    cfg_clr = 1'b1;
    cyc(1'b0, 1'b0);
    cfg_clr = 1'b0;
    chk("t6_clr_frm", fc, 0);
    chk("t6_clr_err", ec, 0);
    for (int i = 0; i < 17; i++) frame();
    chk("t6_frm_cnt32", fc, 17);
    chk("t6_frm_cnt4_sat", fc4, 4'hF);
    frame(FB, FB-1, -1, 16'h0, 0, 1);
    chk("t6_clr_wins32", fc, 0);
    chk("t6_clr_wins4", fc4, 0);
    chk("sb_drained", q_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
